ebus_diag_master: RTL and testbench
===================================

# ebus_diag_master

Console-side diagnostic function driver for the EBUS. It takes one diagnostic request at a time from the front-end console logic and sequences it onto the EBUS diagnostic lines: function select `ds[0:6]`, `diagStrobe`, and the data lines. Load functions (0xx) drive data into the EBOX boards. Read functions (1xx) strobe the selected board and capture the 36-bit word it returns. This block is the initiating end of the diagnostic protocol that the EBOX board decoders (CTL and peers) respond to.

## Interface
Parameters:
- `SETUP_CYC`, 2: cycles that ds/data are stable before the strobe rises; 0 is treated as 1.
- `STROBE_CYC`, 2: cycles `diagStrobe` is high; 0 is treated as 1.
- `HOLD_CYC`, 1: cycles that ds/data are held after the strobe falls; 0 is treated as 1.

Ports:
- `clk` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle and able to accept a request.
- `req_func` in 7: diagnostic function, bit [0] is the MSB (octal 000–177); `req_func[0]`=1 means a read.
- `req_data` in 36: load data, bits [0:35] with bit 0 as MSB.
- `rsp_valid` out 1: one-cycle pulse when read data is captured.
- `rsp_data` out 36: captured read word; held until the next capture.
- `ebus_ds` out 7: EBUS diagnostic function select.
- `ebus_diag_strobe` out 1: EBUS diagStrobe.
- `ebus_data_out` out 36: data driven on loads.
- `ebus_data_oe` out 1: data output enable.
- `ebus_data_in` in 36: EBUS data, sampled on reads.
- `busy` out 1: the inverse of `req_ready`.
- `ebus_parity_out` out 1, and `ebus_parity_in` in 1: present only with the macro (see Configuration).
- `rsp_par_err` out 1: present only with the macro (see Configuration).

## Operation
- State machine: IDLE → SETUP → STROBE → HOLD → IDLE.
- IDLE behaviour:
  - `req_ready`=1.
  - `ebus_ds`=0, so CONSOLE_CONTROL is deasserted at the boards.
  - Strobe, oe and data outputs are 0.
- Accept: `req_valid & req_ready` at a rising edge. On accept:
  - Latch `req_func` and `req_data`.
  - Go to SETUP and load a down-counter with `SETUP_CYC`-1.
- SETUP:
  - `ebus_ds` = the latched function.
  - For loads (`func[0]`=0): `ebus_data_out` = the latched data and `ebus_data_oe`=1.
  - For reads: oe=0 and `ebus_data_out`=0.
  - When the counter reaches 0, go to STROBE.
- STROBE:
  - `ebus_diag_strobe`=1; ds, data and oe are unchanged.
  - Reads: in the last STROBE cycle, register `ebus_data_in` into `rsp_data`.
  - When the counter reaches 0, go to HOLD.
- HOLD:
  - Strobe=0; ds, data and oe are still held.
  - Reads: `rsp_valid`=1 in the first HOLD cycle only.
  - When the counter reaches 0, go to IDLE.
- Requests offered while busy are ignored (`req_ready`=0); `req_valid` can be held.
- The counter is 8 bits wide. Parameters above 256 are illegal.
- All outputs are registered. No combinational path exists from `req_*` to the EBUS pins.

## Timing
- Reset values: `req_ready`=1 and `busy`=0. Every other output is 0, including `rsp_data` and `rsp_valid`.
- Reset mid-operation: the cycle after `RESET` is sampled high, all outputs are at their reset values.
  - The strobe falls immediately.
  - No `rsp_valid` is produced.
  - Any partial transaction is discarded.
- The accept edge is cycle 0. Against that:
  - ds is valid in cycles 1 … SETUP_CYC.
  - Strobe is high in cycles SETUP_CYC+1 … SETUP_CYC+STROBE_CYC.
  - HOLD fills the next HOLD_CYC cycles.
  - `req_ready` returns to 1 in cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+1.
- With default parameters:
  - Strobe is high in cycles 3–4.
  - `rsp_valid` pulses in cycle 5.
  - `req_ready` returns in cycle 6.
  - The next accept can happen at the cycle-6 edge, giving a 6-cycle request-to-request period.
- Back-to-back requests always have at least one IDLE cycle, so ds returns to 0 between transactions.

## Configuration
- `EBUS_DIAG_PARITY_EN` defined:
  - On loads, `ebus_parity_out` drives odd parity over `ebus_data_out`; it is asserted with oe and 0 otherwise.
  - On reads, `ebus_parity_in` is sampled with the data.
  - `rsp_par_err` is asserted with `rsp_valid` if the 36 bits plus parity have an even count of ones.
- `EBUS_DIAG_PARITY_EN` undefined: the three parity ports are absent and no parity logic is generated.

## Test plan
Default parameters unless stated.
- **Load:** func 7'o076, data 36'o000000000400 → `ebus_ds`=7'b0111110 in cycles 1–5, oe=1 in cycles 1–5, strobe=1 in cycles 3–4, ds=0 in cycle 6, `req_ready`=1 in cycle 6.
- **Read:** func 7'o100, `ebus_data_in`=36'o123456701234 → oe=0 throughout, strobe=1 in cycles 3–4, `rsp_valid`=1 only in cycle 5, `rsp_data`=36'o123456701234, and `rsp_data` still holds that value after cycle 5.
- **Back-to-back:** `req_valid` held high with 7'o070 then 7'o071 → second accept at the cycle-6 edge, ds=0 in cycle 6, ds=7'b0111001 in cycle 7.
- **Reset mid-operation:** `RESET`=1 for one cycle in cycle 3 of a read → in cycle 4 strobe=0, ds=0, `req_ready`=1, and `rsp_valid` never pulses.
- **Busy ignore:** a second request pulsed for one cycle in cycle 2 → it is not accepted and the EBUS shows only the first transaction.
- **Parity (macro on):**
  - Load data 36'o1 → `ebus_parity_out`=0.
  - Load data 36'o3 → `ebus_parity_out`=1.
  - Read of 36'o1 with `ebus_parity_in`=1 → `rsp_par_err`=1 in cycle 5.

Source files
------------

// File: rtl/ebus_diag_if.sv
// EBUS diagnostic master interface: console request/response handshake plus
// the EBUS diagnostic lines (ds, diagStrobe, data, oe).
// Optional parity lines exist only when EBUS_DIAG_PARITY_EN is defined.
// Bit numbering: EBUS bit 0 (MSB) lives at the highest index ([6] of ds,
// [35] of data), so octal literals read naturally.
interface ebus_diag_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_func;
  logic [35:0] req_data;
  logic        rsp_valid;
  logic [35:0] rsp_data;
  logic        busy;
  logic [6:0]  ebus_ds;
  logic        ebus_diag_strobe;
  logic [35:0] ebus_data_out;
  logic        ebus_data_oe;
  logic [35:0] ebus_data_in;
`ifdef EBUS_DIAG_PARITY_EN
  logic        ebus_parity_out;
  logic        ebus_parity_in;
  logic        rsp_par_err;

  modport master (
    input  req_valid, req_func, req_data, ebus_data_in, ebus_parity_in,
    output req_ready, rsp_valid, rsp_data, busy, ebus_ds, ebus_diag_strobe,
           ebus_data_out, ebus_data_oe, ebus_parity_out, rsp_par_err
  );
  modport slave (
    output req_valid, req_func, req_data, ebus_data_in, ebus_parity_in,
    input  req_ready, rsp_valid, rsp_data, busy, ebus_ds, ebus_diag_strobe,
           ebus_data_out, ebus_data_oe, ebus_parity_out, rsp_par_err
  );
`else
  modport master (
    input  req_valid, req_func, req_data, ebus_data_in,
    output req_ready, rsp_valid, rsp_data, busy, ebus_ds, ebus_diag_strobe,
           ebus_data_out, ebus_data_oe
  );
  modport slave (
    output req_valid, req_func, req_data, ebus_data_in,
    input  req_ready, rsp_valid, rsp_data, busy, ebus_ds, ebus_diag_strobe,
           ebus_data_out, ebus_data_oe
  );
`endif
endinterface

// File: rtl/ebus_diag_master.sv
// Console-side EBUS diagnostic function driver. Sequences one request at a
// time through SETUP -> STROBE -> HOLD; loads drive data, reads capture the
// returned word at the end of the strobe. Every output is a flop.
// Optional feature macro: EBUS_DIAG_PARITY_EN (odd parity on data lines).
module ebus_diag_master #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic         clk,
  input  logic         RESET,
  ebus_diag_if.master  bus
);

  // A zero-length phase would skip a protocol step, so it is stretched to one.
  localparam int unsigned SETUP_EFF  = (SETUP_CYC  == 0) ? 1 : SETUP_CYC;
  localparam int unsigned STROBE_EFF = (STROBE_CYC == 0) ? 1 : STROBE_CYC;
  localparam int unsigned HOLD_EFF   = (HOLD_CYC   == 0) ? 1 : HOLD_CYC;
  localparam logic [7:0]  SETUP_LD   = 8'(SETUP_EFF - 1);
  localparam logic [7:0]  STROBE_LD  = 8'(STROBE_EFF - 1);
  localparam logic [7:0]  HOLD_LD    = 8'(HOLD_EFF - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [6:0]  func_q, func_nxt;
  logic [35:0] data_q, data_nxt;
  logic        capture;

  logic        ready_q, ready_nxt;
  logic        busy_q;
  logic [6:0]  ds_q, ds_nxt;
  logic        strobe_q, strobe_nxt;
  logic        oe_q, oe_nxt;
  logic [35:0] dout_q, dout_nxt;
  logic        rsp_valid_q;
  logic [35:0] rsp_data_q;
`ifdef EBUS_DIAG_PARITY_EN
  logic        par_out_q, par_out_nxt;
  logic        par_err_q;
`endif

  // Next state, phase counter and the next value of every registered output.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    func_nxt  = func_q;
    data_nxt  = data_q;
    capture   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
          func_nxt  = bus.req_func;
          data_nxt  = bus.req_data;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      STROBE: begin
        if (cnt == 8'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
          capture   = func_q[6];
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are derived from the next state so they can be registered and
    // still line up with the phase they belong to.
    ds_nxt   = '0;
    oe_nxt   = 1'b0;
    dout_nxt = '0;
    if (state_nxt != IDLE) begin
      ds_nxt = func_nxt;
      oe_nxt = ~func_nxt[6];
      if (oe_nxt) dout_nxt = data_nxt;
    end
    strobe_nxt = (state_nxt == STROBE);
    ready_nxt  = (state_nxt == IDLE);
`ifdef EBUS_DIAG_PARITY_EN
    par_out_nxt = oe_nxt & ~(^dout_nxt);
`endif
  end

  // State, latched request and all output flops; RESET wins over everything.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      // Request latches are cleared too so an aborted transfer leaves no residue.
      func_q      <= '0;
      data_q      <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      ds_q        <= '0;
      strobe_q    <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef EBUS_DIAG_PARITY_EN
      par_out_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      func_q      <= func_nxt;
      data_q      <= data_nxt;
      ready_q     <= ready_nxt;
      busy_q      <= ~ready_nxt;
      ds_q        <= ds_nxt;
      strobe_q    <= strobe_nxt;
      oe_q        <= oe_nxt;
      dout_q      <= dout_nxt;
      rsp_valid_q <= capture;
      if (capture) rsp_data_q <= bus.ebus_data_in;
`ifdef EBUS_DIAG_PARITY_EN
      par_out_q   <= par_out_nxt;
      par_err_q   <= capture & ~(^{bus.ebus_data_in, bus.ebus_parity_in});
`endif
    end
  end

  assign bus.req_ready        = ready_q;
  assign bus.busy             = busy_q;
  assign bus.ebus_ds          = ds_q;
  assign bus.ebus_diag_strobe = strobe_q;
  assign bus.ebus_data_oe     = oe_q;
  assign bus.ebus_data_out    = dout_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_data         = rsp_data_q;
`ifdef EBUS_DIAG_PARITY_EN
  assign bus.ebus_parity_out  = par_out_q;
  assign bus.rsp_par_err      = par_err_q;
`endif

endmodule

// File: tb/tb_ebus_diag_master.sv
// Self-checking bench for ebus_diag_master. The driver decides acceptance
// from a transaction-level timing model and queues expected transactions;
// a negedge monitor pops them and compares every observable output each cycle.
module tb_ebus_diag_master;
  localparam int S     = 2;
  localparam int T     = 2;
  localparam int H     = 1;
  localparam int TOTAL = S + T + H;

  logic clk = 1'b0;
  logic RESET;
  int   edge_n = 0;

  ebus_diag_if bus ();

  ebus_diag_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Rising-edge count; interval e is the time between edge e and edge e+1.
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          e0;     // accept edge
    logic [6:0]  func;
    logic [35:0] data;
    int          abort;  // edge at which a reset kills it
  } txn_t;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic [6:0]  ds;
    logic        strobe;
    logic        oe;
    logic [35:0] dout;
    logic        rsp_valid;
    logic [35:0] rsp_data;
    logic        par_out;
    logic        par_err;
  } obs_t;

  txn_t        exp_q[$];
  logic [35:0] din_drv [int];
  logic        pin_drv [int];
  bit          rst_at  [int];
  int          free_edge = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] exp_rsp = '0;

  task automatic check(input string what, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%h required=%h", what, $time, act, exp);
    end
  endtask

  function automatic int last_edge(input txn_t t);
    int a;
    a = t.e0 + TOTAL - 1;
    if (t.abort - 1 < a) a = t.abort - 1;
    return a;
  endfunction

  // Drive inputs sampled at the next edge and update the model accordingly.
  task automatic step(input logic v, input logic [6:0] f, input logic [35:0] d,
                      input logic [35:0] din, input logic pin, input logic rst);
    int nxt;
    txn_t t;
    nxt = edge_n + 1;
    bus.req_valid    = v;
    bus.req_func     = f;
    bus.req_data     = d;
    bus.ebus_data_in = din;
`ifdef EBUS_DIAG_PARITY_EN
    bus.ebus_parity_in = pin;
`endif
    RESET = rst;
    din_drv[edge_n] = din;
    pin_drv[edge_n] = pin;
    if (rst) begin
      rst_at[nxt] = 1'b1;
      foreach (exp_q[i]) if (exp_q[i].abort > nxt) exp_q[i].abort = nxt;
      free_edge = nxt + 1;
    end else if (v && nxt >= free_edge) begin
      t.e0 = nxt; t.func = f; t.data = d; t.abort = 32'h7fff_ffff;
      exp_q.push_back(t);
      free_edge = nxt + TOTAL + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [35:0] din, input logic pin);
    for (int i = 0; i < n; i++) step(1'b0, 7'($urandom), 36'({$urandom, $urandom}), din, pin, 1'b0);
  endtask

  // Monitor: build the expected bus picture for this interval and compare.
  always @(negedge clk) begin
    obs_t act, expv;
    int   e, k;
    if (edge_n >= 1) begin
      e = edge_n;
      while (exp_q.size() > 0 && e > last_edge(exp_q[0])) void'(exp_q.pop_front());
      if (rst_at.exists(e)) exp_rsp = '0;
      expv = '0;
      if (exp_q.size() > 0 && e >= exp_q[0].e0) begin
        k = e - exp_q[0].e0 + 1;
        expv.busy   = 1'b1;
        expv.ds     = exp_q[0].func;
        expv.oe     = ~exp_q[0].func[6];
        expv.dout   = expv.oe ? exp_q[0].data : '0;
        expv.strobe = (k > S) && (k <= S + T);
`ifdef EBUS_DIAG_PARITY_EN
        expv.par_out = expv.oe && (($countones(exp_q[0].data) % 2) == 0);
`endif
        if (exp_q[0].func[6] && k == S + T + 1) begin
          expv.rsp_valid = 1'b1;
          exp_rsp = din_drv[exp_q[0].e0 + S + T - 1];
`ifdef EBUS_DIAG_PARITY_EN
          expv.par_err = (($countones(exp_rsp) + int'(pin_drv[exp_q[0].e0 + S + T - 1])) % 2) == 0;
`endif
        end
      end else begin
        expv.ready = 1'b1;
      end
      expv.rsp_data = exp_rsp;

      act = '0;
      act.ready     = bus.req_ready;
      act.busy      = bus.busy;
      act.ds        = bus.ebus_ds;
      act.strobe    = bus.ebus_diag_strobe;
      act.oe        = bus.ebus_data_oe;
      act.dout      = bus.ebus_data_out;
      act.rsp_valid = bus.rsp_valid;
      act.rsp_data  = bus.rsp_data;
`ifdef EBUS_DIAG_PARITY_EN
      act.par_out   = bus.ebus_parity_out;
      act.par_err   = bus.rsp_par_err;
`endif
      check("bus_cycle", 128'(act), 128'(expv));
    end
  end

  initial begin
    logic [35:0] din;
    int          w;
    // Reset for two edges, then settle.
    step(1'b0, 7'o0, 36'o0, 36'o0, 1'b0, 1'b1);
    step(1'b0, 7'o0, 36'o0, 36'o0, 1'b0, 1'b1);
    check("reset_state",
          {bus.req_ready, bus.busy, bus.ebus_ds, bus.ebus_diag_strobe,
           bus.ebus_data_oe, bus.ebus_data_out, bus.rsp_valid, bus.rsp_data},
          {1'b1, 1'b0, 7'o0, 1'b0, 1'b0, 36'o0, 1'b0, 36'o0});
    idle(2, 36'o0, 1'b0);

    // Load.
    step(1'b1, 7'o076, 36'o000000000400, 36'o777, 1'b0, 1'b0);
    idle(7, 36'o777, 1'b0);

    // Read with a steady return word; rsp_data must keep it afterwards.
    din = 36'o123456701234;
    step(1'b1, 7'o100, 36'o55, din, 1'b0, 1'b0);
    idle(9, din, 1'b0);

    // Back-to-back with req_valid held.
    step(1'b1, 7'o070, 36'o1111, 36'o0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 7'o071, 36'o2222, 36'o0, 1'b0, 1'b0);
    idle(7, 36'o0, 1'b0);

    // Reset in cycle 3 of a read.
    step(1'b1, 7'o123, 36'o0, 36'o707070707070, 1'b0, 1'b0);
    idle(2, 36'o707070707070, 1'b0);
    step(1'b0, 7'o0, 36'o0, 36'o707070707070, 1'b0, 1'b1);
    idle(7, 36'o707070707070, 1'b0);

    // Second request pulsed in cycle 2 while busy.
    step(1'b1, 7'o012, 36'o444, 36'o0, 1'b0, 1'b0);
    idle(1, 36'o0, 1'b0);
    step(1'b1, 7'o055, 36'o333, 36'o0, 1'b0, 1'b0);
    idle(7, 36'o0, 1'b0);

    // Parity corner words.
    step(1'b1, 7'o001, 36'o1, 36'o0, 1'b0, 1'b0);
    idle(6, 36'o0, 1'b0);
    step(1'b1, 7'o001, 36'o3, 36'o0, 1'b0, 1'b0);
    idle(6, 36'o0, 1'b0);
    step(1'b1, 7'o177, 36'o0, 36'o1, 1'b1, 1'b0);
    idle(6, 36'o1, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, 7'($urandom), 36'({$urandom, $urandom}),
           36'({$urandom, $urandom}), 1'($urandom), $urandom_range(0, 79) == 0);

    // Bounded wait for the block to return idle.
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 4 * TOTAL) begin
      idle(1, 36'o0, 1'b0);
      w++;
    end
    check("ready_wait_expired", 128'(w < 4 * TOTAL), 128'(1));

    idle(8, 36'o0, 1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
